ttl_pulse_controller: RTL and testbench
=======================================

# ttl_pulse_controller

Parametrised multi-channel TTL output stage that replaces the single-register TTL latch. It takes the decoded 128-bit command word and its one-cycle select strobe from the GPO core and drives up to 32 TTL lines. Each line supports level, fixed-width pulse and toggle modes. A pulse counter per channel, a registered override path and error/status flags come with it.

## Interface
- OUTPUT_NUM, 8: number of TTL channels, legal range 1..32
- WIDTH_BITS, 16: pulse-width counter width, legal range 1..32
- INIT_VALUE, 0: OUTPUT_NUM-bit reset value of channel state and output_pulse

- clk  in  1  single system clock; all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- selected  in  1  command strobe; one cycle per command
- gpo_out  in  128  command word, sampled only when selected=1
- override_en  in  1  force outputs to override_value
- override_value  in  OUTPUT_NUM  forced output pattern
- output_pulse  out  OUTPUT_NUM  registered TTL outputs
- pulse_active  out  OUTPUT_NUM  per-channel pulse in progress
- overrided  out  1  registered copy of override_en
- cmd_error  out  1  one-cycle flag for an illegal command

## Operation
- Command fields:
  - [127:126] mode: 00 level, 01 pulse, 10 toggle, 11 reserved.
  - [OUTPUT_NUM-1:0] channel mask.
  - [32+OUTPUT_NUM-1:32] level value.
  - [64+WIDTH_BITS-1:64] pulse width W.
  - All other bits are ignored.
- Per-channel state: state bit, active bit, WIDTH_BITS counter cnt.
- Level mode: for each masked channel, state ← value bit, active ← 0. This cancels any running pulse.
- Toggle mode: for each masked channel, state ← ~state, active ← 0.
- Pulse mode with W≥1: for each masked channel, state ← 1, active ← 1, cnt ← W−1.
  - Retrigger on an already-active channel reloads cnt. The pulse is not extended additively.
- Pulse countdown, each cycle with no command to the channel:
  - active=1 and cnt≠0: cnt ← cnt−1.
  - active=1 and cnt=0: state ← 0, active ← 0.
- Unmasked channels are never affected by a command.
- An empty mask is a legal no-op and does not raise an error.
- Errors: cmd_error=1 for one cycle for mode 11, or for pulse mode with W=0. No channel changes.
- Override:
  - output_pulse ← override_en ? override_value : next state.
  - Internal state, counters and commands keep running while overridden.
  - Releasing override shows the current internal state immediately on the next edge.
- Reset values:
  - state=INIT_VALUE, active=0, cnt=0.
  - output_pulse=INIT_VALUE, pulse_active=0, overrided=0, cmd_error=0.
- Reset asserted mid-pulse clears the pulse at once. The channel must not resume after reset release.

## Timing
- Command with selected=1 sampled at edge N: output_pulse and pulse_active update at edge N. They are visible in the cycle after N, giving 1-cycle latency.
- Pulse of width W starting at edge N: output high from edge N through edge N+W−1, low at edge N+W. This is exactly W clock periods high.
- pulse_active falls on the same edge as output_pulse.
- Command on the same edge as natural expiry: the command wins; expiry for that channel is discarded.
- Maximum W is 2^WIDTH_BITS−1. There is no wrap-around; cnt only decrements from the loaded value.
- override_en change at edge N: output_pulse and overrided reflect it at edge N.
- cmd_error is asserted at edge N for a bad command sampled at edge N, and cleared at edge N+1 unless a new bad command arrives.
- Back-to-back commands on consecutive cycles are all accepted. There is no busy/backpressure.

## Test plan
- Reset with INIT_VALUE=8'hA5, toggle reset mid-run -> output_pulse=8'hA5, pulse_active=0 immediately on reset assertion, independent of clk.
- Level cmd, mask=8'h0F, value=8'hFF, then pulse mode mask=8'h10, W=3 -> output_pulse=8'h0F one cycle after first cmd. Bit4 high exactly 3 cycles, pulse_active[4] matching.
- Pulse mode W=5 on ch0, retrigger with W=2 after 3 cycles -> ch0 high 3+2=5 cycles total, then low.
- Pulse mode W=0, then mode 11 -> cmd_error single-cycle high each time, output_pulse unchanged.
- override_en=1, override_value=8'h3C while a W=4 pulse runs on ch1 -> output 8'h3C. After release 6 cycles later, ch1 reads 0 (pulse expired internally), overrided tracks override_en with 1-cycle latency.
- Toggle mask=8'h81 twice on consecutive cycles, plus a level cmd on the same edge as ch2 pulse expiry -> bits 7,0 invert then restore; level value wins on ch2.

Source files
------------

// File: rtl/ttl_pulse_controller.sv
// Multi-channel TTL output stage: per-channel level/pulse/toggle control
// driven by 128-bit GPO command words, with a registered override path.
module ttl_pulse_controller #(
    parameter int                    OUTPUT_NUM = 8,
    parameter int                    WIDTH_BITS = 16,
    parameter logic [OUTPUT_NUM-1:0] INIT_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  selected,
    input  logic [127:0]          gpo_out,
    input  logic                  override_en,
    input  logic [OUTPUT_NUM-1:0] override_value,
    output logic [OUTPUT_NUM-1:0] output_pulse,
    output logic [OUTPUT_NUM-1:0] pulse_active,
    output logic                  overrided,
    output logic                  cmd_error
);

    typedef enum logic [1:0] {
        MODE_LEVEL  = 2'b00,
        MODE_PULSE  = 2'b01,
        MODE_TOGGLE = 2'b10,
        MODE_RSVD   = 2'b11
    } mode_e;

    mode_e                 cmd_mode;
    logic [OUTPUT_NUM-1:0] cmd_mask;
    logic [OUTPUT_NUM-1:0] cmd_value;
    logic [WIDTH_BITS-1:0] cmd_width;
    logic                  cmd_bad;
    logic                  cmd_apply;
    logic                  unused_cmd_bits;

    logic [OUTPUT_NUM-1:0] state_q, state_d;
    logic [OUTPUT_NUM-1:0] active_q, active_d;
    logic [WIDTH_BITS-1:0] cnt_q [OUTPUT_NUM];
    logic [WIDTH_BITS-1:0] cnt_d [OUTPUT_NUM];
    logic [OUTPUT_NUM-1:0] out_q, out_d;
    logic                  ovr_q;
    logic                  err_q;

    assign cmd_mode        = mode_e'(gpo_out[127:126]);
    assign cmd_mask        = gpo_out[OUTPUT_NUM-1:0];
    assign cmd_value       = gpo_out[32 +: OUTPUT_NUM];
    assign cmd_width       = gpo_out[64 +: WIDTH_BITS];
    assign unused_cmd_bits = ^gpo_out;

    // A rejected command touches no channel; countdowns carry on as if idle.
    assign cmd_bad   = selected && ((cmd_mode == MODE_RSVD) ||
                                    ((cmd_mode == MODE_PULSE) && (cmd_width == '0)));
    assign cmd_apply = selected && !cmd_bad;

    always_comb begin
        state_d  = state_q;
        active_d = active_q;
        cnt_d    = cnt_q;
        for (int i = 0; i < OUTPUT_NUM; i++) begin
            if (cmd_apply && cmd_mask[i]) begin
                unique case (cmd_mode)
                    MODE_LEVEL: begin
                        state_d[i]  = cmd_value[i];
                        active_d[i] = 1'b0;
                    end
                    MODE_TOGGLE: begin
                        state_d[i]  = ~state_q[i];
                        active_d[i] = 1'b0;
                    end
                    MODE_PULSE: begin
                        state_d[i]  = 1'b1;
                        active_d[i] = 1'b1;
                        cnt_d[i]    = cmd_width - WIDTH_BITS'(1);
                    end
                    default: begin
                        state_d[i]  = state_q[i];
                        active_d[i] = active_q[i];
                    end
                endcase
            end else if (active_q[i]) begin
                // cnt holds the remaining high cycles minus one
                if (cnt_q[i] != '0) begin
                    cnt_d[i] = cnt_q[i] - WIDTH_BITS'(1);
                end else begin
                    state_d[i]  = 1'b0;
                    active_d[i] = 1'b0;
                end
            end
        end
        out_d = override_en ? override_value : state_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= INIT_VALUE;
            active_q <= '0;
            for (int i = 0; i < OUTPUT_NUM; i++) begin
                cnt_q[i] <= '0;
            end
            out_q    <= INIT_VALUE;
            ovr_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            active_q <= active_d;
            cnt_q    <= cnt_d;
            out_q    <= out_d;
            ovr_q    <= override_en;
            err_q    <= cmd_bad;
        end
    end

    assign output_pulse = out_q;
    assign pulse_active = active_q;
    assign overrided    = ovr_q;
    assign cmd_error    = err_q;

endmodule

// File: tb/tb_ttl_pulse_controller.sv
// Directed and randomized bench for ttl_pulse_controller against a
// remaining-cycles reference model of each channel.
module tb_ttl_pulse_controller;

    localparam int         N    = 8;
    localparam logic [7:0] INIT = 8'hA5;

    logic         clk;
    logic         reset;
    logic         selected;
    logic [127:0] gpo_out;
    logic         override_en;
    logic [7:0]   override_value;
    logic [7:0]   output_pulse;
    logic [7:0]   pulse_active;
    logic         overrided;
    logic         cmd_error;

    int passed = 0;
    int total  = 0;

    // Reference model: per channel, current level and cycles left before a pulse drops.
    logic [7:0] m_st;
    int         m_rem [N];
    logic [7:0] m_out;
    logic       m_err;
    logic       m_ovr;

    ttl_pulse_controller #(
        .OUTPUT_NUM (N),
        .WIDTH_BITS (16),
        .INIT_VALUE (INIT)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .selected       (selected),
        .gpo_out        (gpo_out),
        .override_en    (override_en),
        .override_value (override_value),
        .output_pulse   (output_pulse),
        .pulse_active   (pulse_active),
        .overrided      (overrided),
        .cmd_error      (cmd_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [127:0] mk(input logic [1:0] mode, input logic [7:0] mask,
                                        input logic [7:0] val, input logic [15:0] w);
        logic [127:0] c;
        c          = '0;
        c[127:126] = mode;
        c[7:0]     = mask;
        c[39:32]   = val;
        c[79:64]   = w;
        return c;
    endfunction

    function automatic logic [7:0] m_active();
        logic [7:0] a;
        for (int i = 0; i < N; i++) a[i] = (m_rem[i] > 0);
        return a;
    endfunction

    task automatic model_reset();
        m_st  = INIT;
        for (int i = 0; i < N; i++) m_rem[i] = 0;
        m_out = INIT;
        m_err = 1'b0;
        m_ovr = 1'b0;
    endtask

    task automatic model_edge();
        logic [1:0] mode;
        int         w;
        logic       bad;
        mode = gpo_out[127:126];
        w    = int'(gpo_out[79:64]);
        bad  = (mode == 2'b11) || (mode == 2'b01 && w == 0);
        for (int i = 0; i < N; i++) begin
            if (selected && !bad && gpo_out[i]) begin
                if (mode == 2'b00) begin
                    m_st[i] = gpo_out[32+i]; m_rem[i] = 0;
                end else if (mode == 2'b10) begin
                    m_st[i] = ~m_st[i]; m_rem[i] = 0;
                end else begin
                    m_st[i] = 1'b1; m_rem[i] = w;
                end
            end else if (m_rem[i] > 0) begin
                m_rem[i] = m_rem[i] - 1;
                if (m_rem[i] == 0) m_st[i] = 1'b0;
            end
        end
        m_out = override_en ? override_value : m_st;
        m_err = selected && bad;
        m_ovr = override_en;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic check_all(input string tag);
        check({tag, ".out"}, {24'h0, output_pulse}, {24'h0, m_out});
        check({tag, ".act"}, {24'h0, pulse_active}, {24'h0, m_active()});
        check({tag, ".ovr"}, {31'h0, overrided}, {31'h0, m_ovr});
        check({tag, ".err"}, {31'h0, cmd_error}, {31'h0, m_err});
    endtask

    task automatic step(input string tag, input logic sel, input logic [127:0] cmd,
                        input logic oen, input logic [7:0] oval);
        selected       = sel;
        gpo_out        = cmd;
        override_en    = oen;
        override_value = oval;
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic idle(input string tag);
        step(tag, 1'b0, {$urandom, $urandom, $urandom, $urandom}, 1'b0, 8'h00);
    endtask

    initial begin
        selected       = 1'b0;
        gpo_out        = '0;
        override_en    = 1'b0;
        override_value = 8'h00;
        reset          = 1'b1;
        model_reset();
        #2;
        check_all("reset");
        check("reset_const", {24'h0, output_pulse}, 32'hA5);
        @(posedge clk);
        #2;
        reset = 1'b0;

        // Level then fixed-width pulse on ch4
        step("lvl_clr", 1'b1, mk(2'b00, 8'hFF, 8'h00, 16'd0), 1'b0, 8'h00);
        step("lvl_0F", 1'b1, mk(2'b00, 8'h0F, 8'hFF, 16'd0), 1'b0, 8'h00);
        check("lvl_0F_const", {24'h0, output_pulse}, 32'h0F);
        step("pulse3", 1'b1, mk(2'b01, 8'h10, 8'h00, 16'd3), 1'b0, 8'h00);
        check("pulse3_start", {24'h0, output_pulse}, 32'h1F);
        for (int i = 0; i < 3; i++) idle("pulse3_run");
        check("pulse3_end", {24'h0, output_pulse}, 32'h0F);
        check("pulse3_act", {24'h0, pulse_active}, 32'h00);

        // Retrigger reloads rather than extends
        step("lvl_clr2", 1'b1, mk(2'b00, 8'hFF, 8'h00, 16'd0), 1'b0, 8'h00);
        step("pulse5", 1'b1, mk(2'b01, 8'h01, 8'h00, 16'd5), 1'b0, 8'h00);
        idle("pulse5_run");
        idle("pulse5_run");
        step("retrig2", 1'b1, mk(2'b01, 8'h01, 8'h00, 16'd2), 1'b0, 8'h00);
        idle("retrig_run");
        check("retrig_hi", {24'h0, output_pulse}, 32'h01);
        idle("retrig_end");
        check("retrig_lo", {24'h0, output_pulse}, 32'h00);

        // Illegal commands
        step("w0", 1'b1, mk(2'b01, 8'hFF, 8'hFF, 16'd0), 1'b0, 8'h00);
        check("w0_err", {31'h0, cmd_error}, 32'h1);
        idle("w0_clr");
        step("mode11", 1'b1, mk(2'b11, 8'hFF, 8'hFF, 16'd4), 1'b0, 8'h00);
        check("mode11_out", {24'h0, output_pulse}, 32'h00);
        idle("mode11_clr");
        check("mode11_clr_err", {31'h0, cmd_error}, 32'h0);

        // Override while ch1 pulse runs and expires internally
        step("pulse_ch1", 1'b1, mk(2'b01, 8'h02, 8'h00, 16'd4), 1'b0, 8'h00);
        for (int i = 0; i < 6; i++)
            step("override", 1'b0, '0, 1'b1, 8'h3C);
        check("override_const", {24'h0, output_pulse}, 32'h3C);
        step("release", 1'b0, '0, 1'b0, 8'h3C);
        check("release_const", {24'h0, output_pulse}, 32'h00);

        // Double toggle, then a level command colliding with ch2 expiry
        step("pulse_ch2", 1'b1, mk(2'b01, 8'h04, 8'h00, 16'd3), 1'b0, 8'h00);
        step("tog1", 1'b1, mk(2'b10, 8'h81, 8'h00, 16'd0), 1'b0, 8'h00);
        check("tog1_const", {24'h0, output_pulse}, 32'h85);
        step("tog2", 1'b1, mk(2'b10, 8'h81, 8'h00, 16'd0), 1'b0, 8'h00);
        step("lvl_expiry", 1'b1, mk(2'b00, 8'h04, 8'hFF, 16'd0), 1'b0, 8'h00);
        check("lvl_wins", {24'h0, output_pulse}, 32'h04);
        idle("lvl_hold");
        step("empty_mask", 1'b1, mk(2'b01, 8'h00, 8'h00, 16'd2), 1'b0, 8'h00);

        // Asynchronous reset mid-pulse; the pulse must not resume
        step("pulse_ch3", 1'b1, mk(2'b01, 8'h08, 8'h00, 16'd8), 1'b0, 8'h00);
        idle("pulse_ch3_run");
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        check("async_rst_out", {24'h0, output_pulse}, 32'hA5);
        check("async_rst_act", {24'h0, pulse_active}, 32'h00);
        @(posedge clk);
        #2;
        reset = 1'b0;
        for (int i = 0; i < 10; i++) idle("post_reset");

        // Randomized commands, override and don't-care bits
        for (int i = 0; i < 400; i++) begin
            logic [127:0] c;
            int           r;
            c = {$urandom, $urandom, $urandom, $urandom};
            r = int'($urandom_range(0, 9));
            if (r < 3)       c[127:126] = 2'b01;
            else if (r < 5)  c[127:126] = 2'b00;
            else if (r < 7)  c[127:126] = 2'b10;
            else if (r == 7) c[127:126] = 2'b11;
            c[79:64] = 16'($urandom_range(0, 12));
            step("random", ($urandom_range(0, 2) != 0), c,
                 ($urandom_range(0, 7) == 0), 8'($urandom));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
